// File: rtl/emular_dht11.sv
// DHT11 sensor emulator: detects the host start pulse on the open-drain bus and
// answers with the response preamble followed by a 40-bit humidity/temperature frame.
module emular_dht11 #(
  parameter int unsigned CICLOS_US    = 50,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned ATRASO_US    = 30,
  parameter int unsigned RESP_US      = 80,
  parameter int unsigned BIT_BAIXO_US = 50,
  parameter int unsigned T_ZERO_US    = 26,
  parameter int unsigned T_UM_US      = 70
) (
  input  logic        clock,
  input  logic        reset,
  inout  logic        dht_bus,
  input  logic        habilita,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        erro_checksum,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int unsigned N_START  = START_MIN_US * CICLOS_US;
  localparam int unsigned N_ATRASO = ATRASO_US * CICLOS_US;
  localparam int unsigned N_RESP   = RESP_US * CICLOS_US;
  localparam int unsigned N_BAIXO  = BIT_BAIXO_US * CICLOS_US;
  localparam int unsigned N_ZERO   = T_ZERO_US * CICLOS_US;
  localparam int unsigned N_UM     = T_UM_US * CICLOS_US;

  localparam int unsigned M1    = (N_START > N_ATRASO) ? N_START : N_ATRASO;
  localparam int unsigned M2    = (M1 > N_RESP) ? M1 : N_RESP;
  localparam int unsigned M3    = (M2 > N_BAIXO) ? M2 : N_BAIXO;
  localparam int unsigned M4    = (M3 > N_ZERO) ? M3 : N_ZERO;
  localparam int unsigned N_MAX = (M4 > N_UM) ? M4 : N_UM;
  localparam int unsigned CW    = $clog2(N_MAX + 1);

  localparam logic [CW-1:0] C_START  = CW'(N_START);
  localparam logic [CW-1:0] F_ATRASO = CW'(N_ATRASO - 1);
  localparam logic [CW-1:0] F_RESP   = CW'(N_RESP - 1);
  localparam logic [CW-1:0] F_BAIXO  = CW'(N_BAIXO - 1);
  localparam logic [CW-1:0] F_ZERO   = CW'(N_ZERO - 1);
  localparam logic [CW-1:0] F_UM     = CW'(N_UM - 1);

  typedef enum logic [3:0] {
    ESPERA     = 4'd0,
    ATRASO     = 4'd1,
    RESP_BAIXO = 4'd2,
    RESP_ALTO  = 4'd3,
    BIT_BAIXO  = 4'd4,
    BIT_ALTO   = 4'd5,
    FIM        = 4'd6
  } estado_t;

  estado_t       estado;
  logic          bus_m, bus_s;
  logic          puxa_baixo;
  logic [CW-1:0] cnt;
  logic [39:0]   quadro;
  logic [5:0]    n_bits;
  logic [7:0]    soma;
  logic [7:0]    checksum;
  logic [CW-1:0] fim_alto;

  assign dht_bus   = puxa_baixo ? 1'b0 : 1'bz;
  assign db_estado = estado;

  always_comb begin
    soma     = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
    checksum = erro_checksum ? ~soma : soma;
    fim_alto = quadro[39] ? F_UM : F_ZERO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_m      <= 1'b1;
      bus_s      <= 1'b1;
      estado     <= ESPERA;
      puxa_baixo <= 1'b0;
      cnt        <= '0;
      quadro     <= '0;
      n_bits     <= '0;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      bus_m  <= dht_bus;
      bus_s  <= bus_m;
      pronto <= 1'b0;
      case (estado)
        ESPERA: begin
          puxa_baixo <= 1'b0;
          // A nonzero low count with bus_s high marks the rising edge of the start pulse
          if (bus_s) begin
            cnt <= '0;
            if (cnt >= C_START && habilita) begin
              quadro  <= {umidade, temperatura, checksum};
              n_bits  <= '0;
              ocupado <= 1'b1;
              estado  <= ATRASO;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ATRASO: begin
          if (cnt == F_ATRASO) begin
            cnt <= '0; puxa_baixo <= 1'b1; estado <= RESP_BAIXO;
          end else cnt <= cnt + 1'b1;
        end
        RESP_BAIXO: begin
          if (cnt == F_RESP) begin
            cnt <= '0; puxa_baixo <= 1'b0; estado <= RESP_ALTO;
          end else cnt <= cnt + 1'b1;
        end
        RESP_ALTO: begin
          if (cnt == F_RESP) begin
            cnt <= '0; puxa_baixo <= 1'b1; estado <= BIT_BAIXO;
          end else cnt <= cnt + 1'b1;
        end
        BIT_BAIXO: begin
          if (cnt == F_BAIXO) begin
            cnt <= '0; puxa_baixo <= 1'b0; estado <= BIT_ALTO;
          end else cnt <= cnt + 1'b1;
        end
        BIT_ALTO: begin
          if (cnt == fim_alto) begin
            cnt        <= '0;
            puxa_baixo <= 1'b1;
            quadro     <= {quadro[38:0], 1'b0};
            n_bits     <= n_bits + 1'b1;
            estado     <= (n_bits == 6'd39) ? FIM : BIT_BAIXO;
          end else cnt <= cnt + 1'b1;
        end
        FIM: begin
          if (cnt == F_BAIXO) begin
            cnt        <= '0;
            puxa_baixo <= 1'b0;
            pronto     <= 1'b1;
            ocupado    <= 1'b0;
            n_bits     <= '0;
            estado     <= ESPERA;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          cnt <= '0; puxa_baixo <= 1'b0; ocupado <= 1'b0; estado <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: doc/emular_dht11.md
# emular_dht11

Single-wire DHT11 sensor emulator: the responder side of the DHT11 protocol driven by `medir_dht11`. It watches `dht_bus` for the host start pulse, answers with the DHT11 response preamble, then sends 40 data bits holding externally supplied humidity/temperature and their checksum. It serves as an on-FPGA stand-in for the physical sensor in simulation and in hardware-in-the-loop tests of the measurement path, with knobs to force checksum errors and missing responses.

## Interface
Parameters (all times in µs, scaled by `CICLOS_US`):
- `CICLOS_US`, 50: clock cycles per µs (50 MHz).
- `START_MIN_US`, 18000: minimum host low time accepted as a start.
- `ATRASO_US`, 30: released-bus wait between host release and sensor response.
- `RESP_US`, 80: length of the response low phase and of the response high phase.
- `BIT_BAIXO_US`, 50: low phase before each bit, and the final low phase.
- `T_ZERO_US`, 26: high phase for a 0 bit.
- `T_UM_US`, 70: high phase for a 1 bit.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `dht_bus` inout 1: open-drain bus. The block drives only 0 or z. External pull-up; z reads as 1.
- `habilita` in 1: 0 means starts are ignored and the host times out.
- `umidade` in 16: [15:8] integer part, [7:0] decimal part.
- `temperatura` in 16: same layout as `umidade`.
- `erro_checksum` in 1: 1 means the transmitted checksum is inverted.
- `ocupado` out 1: high from start acceptance to the end of the transaction.
- `pronto` out 1: one-cycle pulse when the transaction completes.
- `db_estado` out 4: current state code.

## Operation
- Bus input passes through a 2-flop synchronizer (`bus_s`). All detection uses `bus_s`.
- States and `db_estado` codes:
  - `ESPERA` (0): bus released. Count consecutive cycles with `bus_s`=0; the count resets to 0 whenever `bus_s`=1.
  - Leave `ESPERA` on a rising edge of `bus_s` when all of these hold: count ≥ `START_MIN_US*CICLOS_US`, `habilita`=1, and the block is not in reset. Otherwise clear the count and stay in `ESPERA`.
  - On acceptance:
    - Snapshot the frame {`umidade[15:8]`, `umidade[7:0]`, `temperatura[15:8]`, `temperatura[7:0]`, checksum} into a 40-bit shift register.
    - Checksum = (sum of the 4 bytes) mod 256, bitwise inverted if `erro_checksum`=1.
    - Set `ocupado`=1 and go to `ATRASO`.
  - `ATRASO` (1): release the bus for `ATRASO_US*CICLOS_US` cycles, then go to `RESP_BAIXO`.
  - `RESP_BAIXO` (2): drive 0 for `RESP_US*CICLOS_US` cycles, then go to `RESP_ALTO`.
  - `RESP_ALTO` (3): release for `RESP_US*CICLOS_US` cycles, then go to `BIT_BAIXO`.
  - `BIT_BAIXO` (4): drive 0 for `BIT_BAIXO_US*CICLOS_US` cycles, then go to `BIT_ALTO`.
  - `BIT_ALTO` (5): release for `T_UM_US*CICLOS_US` cycles if the current MSB is 1, else `T_ZERO_US*CICLOS_US` cycles. Then shift left and increment the bit counter.
    - Bit counter < 40: go to `BIT_BAIXO`.
    - Bit counter = 40: go to `FIM`.
  - `FIM` (6): drive 0 for `BIT_BAIXO_US*CICLOS_US` cycles, then release. Pulse `pronto` for 1 cycle, clear `ocupado`, and return to `ESPERA` with the low count cleared.
- Bits are sent MSB first: humidity integer byte first, checksum last.
- During states 1–6 the bus input is ignored. A host that pulls low mid-response does not abort the transaction.
- Input changes to `umidade`, `temperatura` or `erro_checksum` after acceptance do not affect the frame in flight.
- `habilita` falling mid-transaction does not abort. It only gates new starts.
- A single phase counter is reloaded on every state transition. It is wide enough for `START_MIN_US*CICLOS_US` (≥20 bits at the defaults) and saturates in `ESPERA`.

## Timing
- Reset values: bus released (z), `ocupado`=0, `pronto`=0, `db_estado`=0, counters 0, shift register 0.
- Reset mid-transaction releases the bus on the next edge and returns to `ESPERA`. No `pronto` pulse is issued.
- Acceptance occurs 2 cycles after the host releases the bus (synchronizer delay). `ocupado` rises at the acceptance edge.
- Each phase lasts exactly its programmed cycle count (±0). `dht_bus` drive/release is registered and changes on the state-change edge.
- Total transaction from acceptance to `pronto` = C·(30 + 160 + 40·50 + Σhigh + 50), where C = `CICLOS_US` and Σhigh = 26·(#zeros) + 70·(#ones).
- `pronto` is asserted in the same cycle the bus is released after `FIM`.

## Test plan
- Sim parameters: `CICLOS_US`=2, `START_MIN_US`=100.
- Normal frame: `umidade`=16'h3C00, `temperatura`=16'h1905. Host holds low 120 µs then releases → bus timing matches the phases, decoded frame is 3C 00 19 05 5A, `pronto` pulses once, `ocupado` falls in the same cycle.
- Checksum wrap: `umidade`=16'hFFFF, `temperatura`=16'h0102 → checksum 8'h01.
- Short start: host low 90 µs → no response, bus stays z, state remains 0. A following 120 µs low is accepted normally.
- `habilita`=0 with a valid start → no response. `medir_dht11` with a small `TIMEOUT` reports `erro`.
- `erro_checksum`=1 with the normal frame → checksum 8'hA5 transmitted. `medir_dht11` retries (`db_erro_medida` asserts).
- Reset asserted during `BIT_ALTO` of bit 17 → bus z next cycle, `ocupado`=0, no `pronto`. A new start then yields a full, correct frame.
